// File: rtl/knob_cfg_pkg.sv
// rtl/knob_cfg_pkg.sv - shared types and helpers for the rotary configuration menu
// Purpose: menu state encoding, width helpers and saturating step arithmetic.
// Ports: none (package).
package knob_cfg_pkg;

    typedef enum logic {
        ST_SELECT = 1'b0,
        ST_EDIT   = 1'b1
    } state_e;

    // Width of the field selector; a single-field menu still needs one bit.
    function automatic int sel_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // Width of the upstream rotary counter value.
    function automatic int cnt_width(input int cn);
        return (cn > 1) ? $clog2(cn) : 1;
    endfunction

    // val + step clamped to 2^w - 1; the extra top bit keeps the carry visible.
    function automatic logic [31:0] sat_add(input logic [31:0] val, input logic [31:0] step,
                                            input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, val} + {1'b0, step};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    // val - step clamped to 0.
    function automatic logic [31:0] sat_sub(input logic [31:0] val, input logic [31:0] step,
                                            input int w);
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        return (step > val) ? 32'd0 : ((val - step) & lim[31:0]);
    endfunction

endpackage

// File: rtl/knob_button.sv
// rtl/knob_button.sv - push-button debounce with short/long press classification
// Purpose: debounces the raw active-low button and classifies presses.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   btn_ni       : raw button, active low, already synchronised
//   short_o      : one-cycle pulse on a release before LONG held cycles
//   long_o       : one-cycle pulse when a press has been held LONG cycles
//   edge_o       : one-cycle pulse on any debounced level change
module knob_button #(
    parameter int DB   = 40000,
    parameter int LONG = 50000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_ni,
    output logic short_o,
    output logic long_o,
    output logic edge_o
);

    localparam int DBW = $clog2(DB + 1);
    localparam int LW  = $clog2(LONG + 1);

    logic           raw_press;
    logic           db_q, db_d;
    logic [DBW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0]  hold_q, hold_d;
    logic           holding_q, holding_d;
    logic           long_done_q, long_done_d;
    logic           armed_q, armed_d;

    assign raw_press = ~btn_ni;

    always_comb begin
        db_d        = db_q;
        dcnt_d      = '0;
        edge_o      = 1'b0;
        short_o     = 1'b0;
        hold_d      = hold_q;
        holding_d   = holding_q;

        if (raw_press != db_q) begin
            if (dcnt_q == DBW'(DB - 1)) begin
                db_d   = raw_press;
                edge_o = 1'b1;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        // A press only counts once the button has been seen released since
        // reset, so a button held through reset cannot fire.
        armed_d = armed_q | (~db_q & ~raw_press);

        long_o      = holding_q & db_q & ~long_done_q & (hold_q == LW'(LONG - 1));
        long_done_d = long_done_q | long_o;

        if (holding_q & db_q & ~long_done_q & ~long_o) begin
            hold_d = hold_q + 1'b1;
        end

        if (edge_o & db_d) begin
            if (armed_q) begin
                holding_d   = 1'b1;
                hold_d      = '0;
                long_done_d = 1'b0;
            end
        end else if (edge_o & ~db_d) begin
            // A release after the long press already fired is swallowed.
            short_o   = holding_q & ~long_done_q & ~long_o;
            holding_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            db_q        <= 1'b0;
            dcnt_q      <= '0;
            hold_q      <= '0;
            holding_q   <= 1'b0;
            long_done_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            db_q        <= db_d;
            dcnt_q      <= dcnt_d;
            hold_q      <= hold_d;
            holding_q   <= holding_d;
            long_done_q <= long_done_d;
            armed_q     <= armed_d;
        end
    end

endmodule

// File: rtl/knob_cfg_ctrl.sv
// rtl/knob_cfg_ctrl.sv - rotary encoder + button menu driving K persistent config fields
// Purpose: SELECT mode picks a field, EDIT mode steps it with saturation;
//          short press toggles mode, long press restores defaults, EDIT times out.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   cnt_i        : wrapping rotary counter value (modulus CN)
//   btn_ni       : raw push button, active low, already synchronised
//   cfg_o        : packed fields, field i at [i*W +: W]
//   sel_o        : selected field index
//   edit_o       : 1 = EDIT, 0 = SELECT
//   upd_o        : one-cycle pulse when any field changes
module knob_cfg_ctrl
    import knob_cfg_pkg::*;
#(
    parameter int             K        = 4,
    parameter int             W        = 8,
    parameter int             CN       = 12,
    parameter int             STEP     = 1,
    parameter int             DB       = 40000,
    parameter int             LONG     = 50000000,
    parameter int             TMO      = 500000000,
    parameter logic [K*W-1:0] DEFAULTS = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [$clog2(CN)-1:0]  cnt_i,
    input  logic                   btn_ni,
    output logic [K*W-1:0]         cfg_o,
    output logic [$clog2(K)-1:0]   sel_o,
    output logic                   edit_o,
    output logic                   upd_o
);

    localparam int CW = cnt_width(CN);
    localparam int SW = sel_width(K);
    localparam int IW = $clog2(TMO + 1);
    localparam logic [CW-1:0] CN_LAST = CW'(CN - 1);
    localparam logic [SW-1:0] K_LAST  = SW'(K - 1);

    state_e         state_q, state_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [K*W-1:0] cfg_q, cfg_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic           upd_q, upd_d;
    logic [CW-1:0]  prev_q;
    logic           trk_vld_q;

    logic [CW-1:0]  cnt_up, cnt_dn;
    logic           inc, dec;
    logic           short_w, long_w, btn_edge;
    logic [W-1:0]   field_cur, field_inc, field_dec, field_nxt;

    knob_button #(
        .DB   (DB),
        .LONG (LONG)
    ) u_button (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_ni  (btn_ni),
        .short_o (short_w),
        .long_o  (long_w),
        .edge_o  (btn_edge)
    );

    // Only a single-detent move counts as a step; larger jumps just resync.
    assign cnt_up = (prev_q == CN_LAST) ? '0 : prev_q + 1'b1;
    assign cnt_dn = (prev_q == '0) ? CN_LAST : prev_q - 1'b1;
    assign inc    = trk_vld_q & (cnt_i == cnt_up);
    assign dec    = trk_vld_q & (cnt_i == cnt_dn) & ~inc;

    assign field_cur = cfg_q[sel_q*W +: W];
    assign field_inc = W'(sat_add(32'(field_cur), 32'(STEP), W));
    assign field_dec = W'(sat_sub(32'(field_cur), 32'(STEP), W));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cfg_d     = cfg_q;
        idle_d    = idle_q;
        upd_d     = 1'b0;
        field_nxt = field_cur;

        if (long_w) begin
            // Restore wins over any coincident step.
            cfg_d   = DEFAULTS;
            sel_d   = '0;
            state_d = ST_SELECT;
            idle_d  = '0;
            upd_d   = 1'b1;
        end else begin
            if (state_q == ST_SELECT) begin
                if (inc) begin
                    sel_d = (sel_q == K_LAST) ? '0 : sel_q + 1'b1;
                end else if (dec) begin
                    sel_d = (sel_q == '0) ? K_LAST : sel_q - 1'b1;
                end
                idle_d = '0;
            end else begin
                if (inc) begin
                    field_nxt = field_inc;
                end else if (dec) begin
                    field_nxt = field_dec;
                end
                if (field_nxt != field_cur) begin
                    cfg_d[sel_q*W +: W] = field_nxt;
                    upd_d               = 1'b1;
                end
                // Any activity cancels a timeout landing in the same cycle.
                if (inc | dec | btn_edge) begin
                    idle_d = '0;
                end else if (idle_q == IW'(TMO - 1)) begin
                    state_d = ST_SELECT;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end

            // The step above used the pre-toggle mode.
            if (short_w) begin
                state_d = (state_q == ST_SELECT) ? ST_EDIT : ST_SELECT;
                idle_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_SELECT;
            sel_q     <= '0;
            cfg_q     <= DEFAULTS;
            idle_q    <= '0;
            upd_q     <= 1'b0;
            prev_q    <= '0;
            trk_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cfg_q     <= cfg_d;
            idle_q    <= idle_d;
            upd_q     <= upd_d;
            prev_q    <= cnt_i;
            trk_vld_q <= 1'b1;
        end
    end

    assign cfg_o  = cfg_q;
    assign sel_o  = sel_q;
    assign edit_o = (state_q == ST_EDIT);
    assign upd_o  = upd_q;

endmodule

// File: tb/tb_knob_cfg_ctrl.sv
// tb/tb_knob_cfg_ctrl.sv - self-checking bench for knob_cfg_ctrl
module tb_knob_cfg_ctrl;

    localparam int K = 4, W = 8, CN = 12, STEP = 1, DB = 4, LONG = 20, TMO = 50;
    localparam logic [31:0] DEF = 32'hFF302010;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  cnt_i = 4'd0;
    logic        btn_ni = 1'b1;
    logic [31:0] cfg_o;
    logic [1:0]  sel_o;
    logic        edit_o;
    logic        upd_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_cnt = 0;

    knob_cfg_ctrl #(
        .K(K), .W(W), .CN(CN), .STEP(STEP), .DB(DB), .LONG(LONG), .TMO(TMO), .DEFAULTS(DEF)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cnt_i  (cnt_i),
        .btn_ni (btn_ni),
        .cfg_o  (cfg_o),
        .sel_o  (sel_o),
        .edit_o (edit_o),
        .upd_o  (upd_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: timestamps instead of counters, plain int fields.
    int m_fld[K];
    int m_sel, m_prev, m_diff_start, m_press_t, m_last_act, m_t;
    bit m_edit, m_upd, m_first, m_db, m_armed, m_holding, m_long_done;

    function automatic logic [31:0] m_cfg();
        logic [31:0] r = '0;
        for (int i = 0; i < K; i++) r = r | (32'(m_fld[i]) << (W * i));
        return r;
    endfunction

    task automatic model_edge(input bit rst, input int cnt, input bit btn);
        bit raw_p, flip, long_ev, short_ev, was_edit;
        int step, v;
        m_t++;
        m_upd = 0;
        if (rst) begin
            for (int i = 0; i < K; i++) m_fld[i] = int'((DEF >> (W * i)) & 32'hFF);
            m_sel = 0; m_edit = 0; m_first = 1; m_db = 0; m_diff_start = -1;
            m_armed = 0; m_holding = 0; m_long_done = 0; m_last_act = m_t;
            return;
        end
        step = 0;
        if (!m_first) begin
            v = (cnt - m_prev + CN) % CN;
            if (v == 1) step = 1;
            else if (v == CN - 1) step = -1;
        end
        m_first = 0;
        m_prev  = cnt;

        raw_p = !btn;
        flip  = 0;
        if (raw_p == m_db) m_diff_start = -1;
        else begin
            if (m_diff_start < 0) m_diff_start = m_t;
            if (m_t - m_diff_start + 1 == DB) begin flip = 1; m_diff_start = -1; end
        end
        long_ev  = m_holding && m_db && !m_long_done && (m_t - m_press_t == LONG);
        short_ev = 0;
        if (flip && !m_db) begin
            if (m_armed) begin m_holding = 1; m_press_t = m_t; m_long_done = 0; end
        end else if (flip && m_db) begin
            short_ev  = m_holding && !m_long_done && !long_ev;
            m_holding = 0;
        end
        if (long_ev) m_long_done = 1;
        if (!m_db && !raw_p) m_armed = 1;
        if (flip) m_db = !m_db;

        was_edit = m_edit;
        if (long_ev) begin
            for (int i = 0; i < K; i++) m_fld[i] = int'((DEF >> (W * i)) & 32'hFF);
            m_sel = 0; m_edit = 0; m_upd = 1;
            return;
        end
        if (!was_edit) begin
            if (step != 0) m_sel = (m_sel + step + K) % K;
        end else begin
            if (step != 0) begin
                v = m_fld[m_sel] + step * STEP;
                if (v > (1 << W) - 1) v = (1 << W) - 1;
                if (v < 0) v = 0;
                if (v != m_fld[m_sel]) begin m_fld[m_sel] = v; m_upd = 1; end
            end
            if (step != 0 || flip) m_last_act = m_t;
            else if (m_t - m_last_act == TMO) m_edit = 0;
        end
        if (short_ev) begin m_edit = !was_edit; m_last_act = m_t; end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input int cnt, input bit btn);
        rst_i  = rst;
        cnt_i  = 4'(cnt);
        btn_ni = btn;
        @(posedge clk_i);
        #1;
        model_edge(rst, cnt, btn);
        check("model.cfg", cfg_o, m_cfg());
        check("model.sel", 32'(sel_o), 32'(m_sel));
        check("model.edit", 32'(edit_o), 32'(m_edit));
        check("model.upd", 32'(upd_o), 32'(m_upd));
    endtask

    task automatic idle_n(input int n, input bit btn);
        for (int i = 0; i < n; i++) cycle(0, cur_cnt, btn);
    endtask

    task automatic step_up();
        cur_cnt = (cur_cnt + 1) % CN;
        cycle(0, cur_cnt, 1);
    endtask

    task automatic step_dn();
        cur_cnt = (cur_cnt + CN - 1) % CN;
        cycle(0, cur_cnt, 1);
    endtask

    task automatic press_short();
        idle_n(8, 0);
        idle_n(DB + 2, 1);
    endtask

    typedef struct {
        bit          rst;
        int          cnt;
        bit          btn;
        int          sel;
        bit          edit;
        bit          upd;
        logic [31:0] cfg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input int cnt, input bit btn, input int sel,
                       input bit edit, input bit upd, input logic [31:0] cfg);
        vec_t v;
        v.rst = rst; v.cnt = cnt; v.btn = btn; v.sel = sel;
        v.edit = edit; v.upd = upd; v.cfg = cfg;
        tbl.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int pulses;
        int run_left;
        int r;
        int act_pct;
        bit rb;
        bit rr;

        // Selection walk, resync jump, wrap below zero, short press, saturation at 0xFF.
        add(1, 5, 1, 0, 0, 0, DEF);
        add(0, 5, 1, 0, 0, 0, DEF);
        add(0, 6, 1, 1, 0, 0, DEF);
        add(0, 7, 1, 2, 0, 0, DEF);
        add(0, 6, 1, 1, 0, 0, DEF);
        add(0, 5, 1, 0, 0, 0, DEF);
        add(0, 0, 1, 0, 0, 0, DEF);
        add(0, 11, 1, 3, 0, 0, DEF);
        for (int i = 0; i < 8; i++) add(0, 11, 0, 3, 0, 0, DEF);
        for (int i = 0; i < 3; i++) add(0, 11, 1, 3, 0, 0, DEF);
        add(0, 11, 1, 3, 1, 0, DEF);
        add(0, 0, 1, 3, 1, 0, DEF);
        add(0, 11, 1, 3, 1, 1, 32'hFE302010);
        add(0, 10, 1, 3, 1, 1, 32'hFD302010);

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].cnt, tbl[i].btn);
            check($sformatf("tbl%0d.sel", i), 32'(sel_o), 32'(tbl[i].sel));
            check($sformatf("tbl%0d.edit", i), 32'(edit_o), 32'(tbl[i].edit));
            check($sformatf("tbl%0d.upd", i), 32'(upd_o), 32'(tbl[i].upd));
            check($sformatf("tbl%0d.cfg", i), cfg_o, tbl[i].cfg);
        end
        cur_cnt = 10;

        // Sub-debounce glitch, then a non-detent jump.
        idle_n(3, 0);
        idle_n(5, 1);
        check("glitch.edit", 32'(edit_o), 32'd1);
        cur_cnt = 4; cycle(0, cur_cnt, 1);
        cur_cnt = 9; cycle(0, cur_cnt, 1);
        check("jump.cfg", cfg_o, 32'hFD302010);

        // Field0 driven down past zero, then inactivity timeout.
        press_short();
        check("to_select.edit", 32'(edit_o), 32'd0);
        step_up();
        check("wrap_sel", 32'(sel_o), 32'd0);
        press_short();
        check("to_edit.edit", 32'(edit_o), 32'd1);
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            step_dn();
            pulses += int'(upd_o);
        end
        check("sat0.pulses", 32'(pulses), 32'd16);
        check("sat0.cfg", cfg_o, 32'hFD302000);
        idle_n(TMO - 1, 1);
        check("tmo_minus1.edit", 32'(edit_o), 32'd1);
        idle_n(1, 1);
        check("tmo.edit", 32'(edit_o), 32'd0);

        // Edit field1 to 0x25, then long press restore.
        step_up();
        press_short();
        for (int i = 0; i < 5; i++) step_up();
        check("f1.cfg", cfg_o, 32'hFD302500);
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle(0, cur_cnt, 0);
            pulses += int'(upd_o);
            if (i == DB + LONG - 1) check("pre_long.edit", 32'(edit_o), 32'd1);
            if (i == DB + LONG) begin
                check("long.upd", 32'(upd_o), 32'd1);
                check("long.cfg", cfg_o, DEF);
            end
        end
        check("long.pulses", 32'(pulses), 32'd1);
        idle_n(8, 1);
        check("long_rel.edit", 32'(edit_o), 32'd0);
        check("long_rel.sel", 32'(sel_o), 32'd0);

        // Reset during EDIT with the button held.
        press_short();
        step_up();
        check("pre_rst.cfg", cfg_o, 32'hFF302011);
        idle_n(6, 0);
        cycle(1, cur_cnt, 0);
        check("rst.cfg", cfg_o, DEF);
        check("rst.sel", 32'(sel_o), 32'd0);
        check("rst.edit", 32'(edit_o), 32'd0);
        check("rst.upd", 32'(upd_o), 32'd0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(0, cur_cnt, 0);
            pulses += int'(upd_o);
        end
        check("held_rst.pulses", 32'(pulses), 32'd0);
        check("held_rst.edit", 32'(edit_o), 32'd0);
        idle_n(6, 1);
        check("held_rel.edit", 32'(edit_o), 32'd0);
        press_short();
        check("repress.edit", 32'(edit_o), 32'd1);

        // Randomised traffic against the model, alternating busy and quiet stretches.
        run_left = 0;
        rb = 1;
        for (int c = 0; c < 3000; c++) begin
            act_pct = ((c / 200) % 2 == 0) ? 30 : 2;
            if (run_left == 0) begin
                rb = ~rb;
                run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40))
                                                       : int'($urandom_range(1, 8));
            end
            run_left--;
            r = int'($urandom_range(0, 99));
            if (r < act_pct / 2) cur_cnt = (cur_cnt + 1) % CN;
            else if (r < act_pct) cur_cnt = (cur_cnt + CN - 1) % CN;
            else if (r >= 98) cur_cnt = int'($urandom_range(0, CN - 1));
            rr = ($urandom_range(0, 399) == 0);
            cycle(rr, cur_cnt, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
